// File: rtl/ysyx_22040088_mem_arb_pkg.sv
// Shared FSM-state and owner encodings for the IFU/LSU memory arbiter.
// Pure type and function definitions, no timing or flow control of its own.
package ysyx_22040088_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    // grant is one-hot {ls, if}; a zero grant maps to OWN_IF but is never used
    function automatic owner_t grant_owner(input logic [1:0] grant);
        return grant[1] ? OWN_LS : OWN_IF;
    endfunction

endpackage

// File: rtl/ysyx_22040088_mem_arb_if.sv
// IFU/LSU request-response channels plus the shared memory port; slave is the arbiter side.
// Plain wires, no latency; valid/ready handshakes on requests, single-cycle response pulses.
interface ysyx_22040088_mem_arb_if #(
    parameter int AW = 64,
    parameter int DW = 64
);
    logic            if_req_valid;
    logic            if_req_ready;
    logic [AW-1:0]   if_addr;
    logic            if_resp_valid;
    logic [DW-1:0]   if_rdata;

    logic            ls_req_valid;
    logic            ls_req_ready;
    logic            ls_wen;
    logic [AW-1:0]   ls_addr;
    logic [DW-1:0]   ls_wdata;
    logic [DW/8-1:0] ls_wmask;
    logic            ls_resp_valid;
    logic [DW-1:0]   ls_rdata;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic            mem_wen;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_wmask;
    logic            mem_resp_valid;
    logic [DW-1:0]   mem_rdata;

    modport slave (
        input  if_req_valid, if_addr,
        input  ls_req_valid, ls_wen, ls_addr, ls_wdata, ls_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output if_req_ready, if_resp_valid, if_rdata,
        output ls_req_ready, ls_resp_valid, ls_rdata,
        output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output if_req_valid, if_addr,
        output ls_req_valid, ls_wen, ls_addr, ls_wdata, ls_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  if_req_ready, if_resp_valid, if_rdata,
        input  ls_req_ready, ls_resp_valid, ls_rdata,
        input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
    );

endinterface

// File: rtl/ysyx_22040088_mem_arb_rr_arb2.sv
// Two-way round-robin selector returning a one-hot grant {valid1, valid0}.
// Purely combinational; on a conflict the requester that did not win last time is chosen.
module ysyx_22040088_rr_arb2
    import ysyx_22040088_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  owner_t     last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid0 && valid1) begin
            grant = (last == OWN_IF) ? 2'b10 : 2'b01;
        end else if (valid0) begin
            grant = 2'b01;
        end else if (valid1) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/ysyx_22040088_mem_arb.sv
// Arbitrates IFU and LSU onto one memory port, one transaction in flight; 3-cycle minimum accept-to-response.
// Requesters see ready only in IDLE; mem_req_valid and fields are held until mem_req_ready.
module ysyx_22040088_mem_arb
    import ysyx_22040088_pkg::*;
#(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    ysyx_22040088_mem_arb_if.slave bus
);

    localparam int MW = DW / 8;

    state_t          state;
    owner_t          owner;
    owner_t          last_grant;
    logic [1:0]      grant;
    logic            accept;

    logic            mem_req_valid_q;
    logic            mem_wen_q;
    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_wdata_q;
    logic [MW-1:0]   mem_wmask_q;

    logic            if_resp_valid_q;
    logic            ls_resp_valid_q;
    logic [DW-1:0]   if_rdata_q;
    logic [DW-1:0]   ls_rdata_q;

    ysyx_22040088_rr_arb2 u_rr (
        .valid0 (bus.if_req_valid),
        .valid1 (bus.ls_req_valid),
        .last   (last_grant),
        .grant  (grant)
    );

    // readies are gated by reset so an asserted valid cannot be acknowledged during reset
    assign accept           = rst && (state == ST_IDLE) && (grant != 2'b00);
    assign bus.if_req_ready = accept && grant[0];
    assign bus.ls_req_ready = accept && grant[1];

    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_wen       = mem_wen_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.mem_wmask     = mem_wmask_q;
    assign bus.if_resp_valid = if_resp_valid_q;
    assign bus.if_rdata      = if_rdata_q;
    assign bus.ls_resp_valid = ls_resp_valid_q;
    assign bus.ls_rdata      = ls_rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_IDLE;
            owner           <= OWN_IF;
            last_grant      <= OWN_IF;
            mem_req_valid_q <= 1'b0;
            mem_wen_q       <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_wmask_q     <= '0;
            if_resp_valid_q <= 1'b0;
            ls_resp_valid_q <= 1'b0;
            if_rdata_q      <= '0;
            ls_rdata_q      <= '0;
        end else begin
            if_resp_valid_q <= 1'b0;
            ls_resp_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        owner           <= grant_owner(grant);
                        last_grant      <= grant_owner(grant);
                        mem_req_valid_q <= 1'b1;
                        if (grant[1]) begin
                            mem_wen_q   <= bus.ls_wen;
                            mem_addr_q  <= bus.ls_addr;
                            mem_wdata_q <= bus.ls_wdata;
                            mem_wmask_q <= bus.ls_wmask;
                        end else begin
                            mem_wen_q   <= 1'b0;
                            mem_addr_q  <= bus.if_addr;
                            mem_wdata_q <= '0;
                            mem_wmask_q <= '0;
                        end
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state           <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        if (owner == OWN_LS) begin
                            ls_resp_valid_q <= 1'b1;
                            // a store acknowledge carries no data worth keeping
                            if (!mem_wen_q) begin
                                ls_rdata_q <= bus.mem_rdata;
                            end
                        end else begin
                            if_resp_valid_q <= 1'b1;
                            if_rdata_q      <= bus.mem_rdata;
                        end
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040088_mem_arb.sv
// Directed, table-driven bench for the IFU/LSU memory arbiter plus hand-written corner sequences.
module tb_ysyx_22040088_mem_arb;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    ysyx_22040088_mem_arb_if #(.AW(64), .DW(64)) bus ();

    ysyx_22040088_mem_arb #(.AW(64), .DW(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_ls;
        bit          wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        int          stall;
        logic [63:0] rdata;
        logic [63:0] exp_if_rdata;
        logic [63:0] exp_ls_rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with the request driven; returns at the negedge after the response pulse.
    task automatic serve(input vec_t v, input bit drop, output int waited);
        int t;
        t = 0;
        while (bus.mem_req_valid !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        waited = t;
        check("req_timeout", 64'(t < 20), 64'd1);
        if (drop) begin
            bus.if_req_valid = 1'b0;
            bus.ls_req_valid = 1'b0;
        end
        for (int s = 0; s <= v.stall; s++) begin
            check("mem_req_valid_held", bus.mem_req_valid, 1'b1);
            check("mem_addr", bus.mem_addr, v.addr);
            check("mem_wen", bus.mem_wen, v.wen);
            check("mem_wmask", bus.mem_wmask, v.wmask);
            if (v.wen) check("mem_wdata", bus.mem_wdata, v.wdata);
            bus.mem_req_ready = (s == v.stall);
            @(negedge clk);
        end
        bus.mem_req_ready = 1'b0;
        check("wait_req_valid_low", bus.mem_req_valid, 1'b0);
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = v.rdata;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        check("if_resp_valid", bus.if_resp_valid, !v.is_ls);
        check("ls_resp_valid", bus.ls_resp_valid, v.is_ls);
        check("if_rdata", bus.if_rdata, v.exp_if_rdata);
        check("ls_rdata", bus.ls_rdata, v.exp_ls_rdata);
        @(negedge clk);
        check("if_resp_one_cycle", bus.if_resp_valid, 1'b0);
        check("ls_resp_one_cycle", bus.ls_resp_valid, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_if_ready"}, bus.if_req_ready, 1'b0);
        check({tag, "_ls_ready"}, bus.ls_req_ready, 1'b0);
        check({tag, "_mem_req_valid"}, bus.mem_req_valid, 1'b0);
        check({tag, "_mem_wen"}, bus.mem_wen, 1'b0);
        check({tag, "_mem_wmask"}, bus.mem_wmask, 8'h00);
        check({tag, "_mem_addr"}, bus.mem_addr, 64'h0);
        check({tag, "_if_resp_valid"}, bus.if_resp_valid, 1'b0);
        check({tag, "_ls_resp_valid"}, bus.ls_resp_valid, 1'b0);
        check({tag, "_if_rdata"}, bus.if_rdata, 64'h0);
        check({tag, "_ls_rdata"}, bus.ls_rdata, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   w;
        logic [63:0] eif;
        logic [63:0] els;

        n_checks = 0;
        n_fail   = 0;

        //            is_ls wen addr                  wdata                  wmask  stall rdata                  exp_if        exp_ls
        vecs[0] = '{1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'h0, 8'h00, 0, 64'h0000_0000_0000_0413, 64'h413, 64'h0};
        vecs[1] = '{1'b1, 1'b0, 64'h0000_0000_8000_0008, 64'h0, 8'h00, 1, 64'hDEAD_BEEF_CAFE_F00D, 64'h413, 64'hDEAD_BEEF_CAFE_F00D};
        vecs[2] = '{1'b1, 1'b1, 64'h0000_0000_8000_1000, 64'h1122_3344_5566_7788, 8'h0F, 5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h413, 64'hDEAD_BEEF_CAFE_F00D};
        vecs[3] = '{1'b0, 1'b0, 64'h0000_0000_8000_0004, 64'h0, 8'h00, 2, 64'h0000_0000_0010_0093, 64'h0010_0093, 64'hDEAD_BEEF_CAFE_F00D};
        vecs[4] = '{1'b1, 1'b0, 64'h0000_0000_8000_0010, 64'h0, 8'h00, 0, 64'h0123_4567_89AB_CDEF, 64'h0010_0093, 64'h0123_4567_89AB_CDEF};

        rst = 1'b0;
        bus.if_req_valid   = 1'b1;
        bus.if_addr        = 64'h0;
        bus.ls_req_valid   = 1'b1;
        bus.ls_wen         = 1'b0;
        bus.ls_addr        = 64'h0;
        bus.ls_wdata       = 64'h0;
        bus.ls_wmask       = 8'h00;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = 64'h0;
        #3;
        check_all_zero("reset");
        bus.if_req_valid = 1'b0;
        bus.ls_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Single-requester transactions, with accept-to-mem_req latency checked
        for (int i = 0; i < 5; i++) begin
            v = vecs[i];
            if (v.is_ls) begin
                bus.ls_req_valid = 1'b1;
                bus.ls_wen       = v.wen;
                bus.ls_addr      = v.addr;
                bus.ls_wdata     = v.wdata;
                bus.ls_wmask     = v.wmask;
            end else begin
                bus.if_req_valid = 1'b1;
                bus.if_addr      = v.addr;
            end
            #1;
            check("tbl_if_ready", bus.if_req_ready, !v.is_ls);
            check("tbl_ls_ready", bus.ls_req_ready, v.is_ls);
            @(negedge clk);
            serve(v, 1'b1, w);
            check("tbl_accept_latency", 64'(w), 64'd0);
        end

        // Both requesters valid straight out of reset: LSU, IFU, LSU, IFU
        @(negedge clk);
        rst = 1'b0;
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 64'h8000_0100;
        bus.ls_req_valid = 1'b1;
        bus.ls_wen       = 1'b0;
        bus.ls_addr      = 64'h8000_0200;
        bus.ls_wdata     = 64'h0;
        bus.ls_wmask     = 8'h00;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rr_first_ls_ready", bus.ls_req_ready, 1'b1);
        check("rr_first_if_ready", bus.if_req_ready, 1'b0);
        @(negedge clk);
        eif = 64'h0;
        els = 64'h0;
        for (int k = 0; k < 4; k++) begin
            v.is_ls = (k % 2 == 0);
            v.wen   = 1'b0;
            v.addr  = v.is_ls ? 64'h8000_0200 : 64'h8000_0100;
            v.wdata = 64'h0;
            v.wmask = 8'h00;
            v.stall = k % 2;
            v.rdata = v.is_ls ? (64'hAAAA_0000 + 64'(k)) : (64'hBBBB_0000 + 64'(k));
            if (v.is_ls) els = v.rdata;
            else         eif = v.rdata;
            v.exp_if_rdata = eif;
            v.exp_ls_rdata = els;
            serve(v, 1'b0, w);
        end
        bus.if_req_valid = 1'b0;
        bus.ls_req_valid = 1'b0;
        @(negedge clk);

        // Reset asserted while waiting for the memory response
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 64'h8000_0300;
        @(negedge clk);
        check("rst_wait_in_req", bus.mem_req_valid, 1'b1);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        check("rst_wait_in_wait", bus.mem_req_valid, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("rst_in_wait");
        bus.if_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 64'h9999;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("late_resp_if_valid", bus.if_resp_valid, 1'b0);
            check("late_resp_ls_valid", bus.ls_resp_valid, 1'b0);
            check("late_resp_if_rdata", bus.if_rdata, 64'h0);
            @(negedge clk);
        end

        // Spurious responses in IDLE and in REQ
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 64'h5555;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("idle_spur_req_valid", bus.mem_req_valid, 1'b0);
            check("idle_spur_if_resp", bus.if_resp_valid, 1'b0);
            check("idle_spur_ls_resp", bus.ls_resp_valid, 1'b0);
        end
        bus.ls_req_valid = 1'b1;
        bus.ls_wen       = 1'b0;
        bus.ls_addr      = 64'h8000_0400;
        bus.ls_wmask     = 8'h00;
        #1;
        check("idle_spur_still_idle", bus.ls_req_ready, 1'b1);
        @(negedge clk);
        bus.ls_req_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            check("req_spur_req_valid", bus.mem_req_valid, 1'b1);
            check("req_spur_ls_resp", bus.ls_resp_valid, 1'b0);
            @(negedge clk);
        end
        bus.mem_resp_valid = 1'b0;
        v = '{1'b1, 1'b0, 64'h8000_0400, 64'h0, 8'h00, 0, 64'h77, 64'h0, 64'h77};
        serve(v, 1'b1, w);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22040088_mem_arb.md
YSYX_22040088_MEM_ARB -- requirements
Module: ysyx_22040088_mem_arb

Interface
REQ-001 Parameter AW, default 64, SHALL set the address width of all address ports.
REQ-002 Parameter DW, default 64, SHALL set the data width; mask width SHALL be DW/8.
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  in  1  SHALL be an asynchronous, active-low reset.
REQ-005 if_req_valid  in  1  SHALL signal an IFU instruction-fetch read request.
REQ-006 if_req_ready  out  1  SHALL signal that the IFU request is accepted this cycle.
REQ-007 if_addr  in  AW  SHALL carry the fetch address.
REQ-008 if_resp_valid  out  1  SHALL be a one-cycle pulse carrying valid fetch data.
REQ-009 if_rdata  out  DW  SHALL carry the fetch data.
REQ-010 ls_req_valid  in  1  SHALL signal an LSU load/store request.
REQ-011 ls_req_ready  out  1  SHALL signal that the LSU request is accepted this cycle.
REQ-012 ls_wen / ls_addr / ls_wdata / ls_wmask  in  1/AW/DW/DW/8  SHALL carry write-enable, address, store data and byte mask.
REQ-013 ls_resp_valid / ls_rdata  out  1/DW  SHALL carry the load data or store acknowledge (one-cycle pulse).
REQ-014 mem_req_valid / mem_req_ready  out/in  1/1  SHALL form the memory-port request handshake.
REQ-015 mem_wen / mem_addr / mem_wdata / mem_wmask  out  1/AW/DW/DW/8  SHALL carry the registered request fields.
REQ-016 mem_resp_valid / mem_rdata  in  1/DW  SHALL carry the memory response.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, REQ, WAIT and RESP; exactly one transaction SHALL be outstanding at a time.
REQ-018 Ready signals SHALL be asserted only in IDLE; *_req_ready SHALL be combinational from the state, both valid inputs and last_grant.
REQ-019 Arbitration SHALL be round-robin: when only one requester is valid, it wins; when both are valid, the requester not in last_grant wins.
REQ-020 On acceptance, the fields and owner SHALL be registered, last_grant SHALL update to the owner, and the FSM SHALL go IDLE->REQ.
REQ-021 IFU requests SHALL be issued with mem_wen=0 and mem_wmask=0.
REQ-022 In REQ, mem_req_valid SHALL be 1 and the mem_* fields SHALL be held stable; on mem_req_ready=1 the FSM SHALL go REQ->WAIT.
REQ-023 In WAIT, on mem_resp_valid=1 mem_rdata SHALL be captured into the owner's rdata register and the FSM SHALL go WAIT->RESP.
REQ-024 In RESP, the owner's *_resp_valid SHALL be 1 for exactly one cycle, then the FSM SHALL go RESP->IDLE.
REQ-025 mem_resp_valid outside WAIT SHALL be ignored.
REQ-026 For stores, ls_rdata SHALL keep its previous value.
REQ-027 rdata registers SHALL hold their value until the next response to the same owner.
REQ-028 Minimum latency SHALL be: accept at cycle N, mem_req_valid at N+1, *_resp_valid at N+3 when mem_req_ready=1 at N+1 and mem_resp_valid=1 at N+2.
REQ-029 A requester SHALL never be granted twice in a row while the other is continuously valid.

Reset
REQ-030 rst=0 SHALL immediately force IDLE, last_grant=IFU (so the first conflict goes to LSU), all *_ready, *_valid, mem_wen and mem_wmask to 0, and all address/data registers to 0.
REQ-031 Reset mid-transaction SHALL abandon the transaction with no response; a late mem_resp_valid after release SHALL be ignored per REQ-025.

Structure
REQ-032 State encoding and the owner encoding (OWN_IF, OWN_LS) SHALL be placed in the shared ysyx_22040088 package.
REQ-033 Round-robin selection SHALL be one sub-module, ysyx_22040088_rr_arb2, taking (valid0, valid1, last) and returning a one-hot grant; the rest is flat.

Verification
REQ-034 Lone IFU read, addr 0x80000000, memory ready immediately, responds next cycle with 0x00000413 -> if_resp_valid 3 cycles after accept, if_rdata=0x00000413, ls_resp_valid stays 0.
REQ-035 Both requesters valid from reset, held continuously -> grant order LSU, IFU, LSU, IFU; each owner receives exactly its own response.
REQ-036 LSU store, addr 0x80001000, wdata 0x1122334455667788, mask 0x0F, mem_req_ready held 0 for 5 cycles -> mem_* fields stable all 5 cycles; a single ls_resp_valid follows; ls_rdata unchanged.
REQ-037 rst=0 asserted while in WAIT -> all outputs 0 asynchronously; a mem_resp_valid after release produces no *_resp_valid.
REQ-038 Spurious mem_resp_valid during IDLE and REQ -> no response pulses and no state change.
